// File: rtl/fetch_stage_if.sv
// fetch_stage_if: memory request/response, redirect and decode handshake signals of the fetch stage
interface fetch_stage_if #(parameter int WORD_SIZE = 32);
    logic                 redirect;
    logic [31:0]          redirectPC;
    logic                 readEnable;
    logic [31:0]          readAddress;
    logic [WORD_SIZE-1:0] instruction;
    logic                 ready;
    logic                 busy;
    logic                 decValid;
    logic [WORD_SIZE-1:0] decInstr;
    logic [31:0]          decPC;
    logic                 decReady;
    modport master (
        input  redirect, redirectPC, instruction, ready, busy, decReady,
        output readEnable, readAddress, decValid, decInstr, decPC
    );
    modport slave (
        output redirect, redirectPC, instruction, ready, busy, decReady,
        input  readEnable, readAddress, decValid, decInstr, decPC
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner issuing one-at-a-time memory reads, buffering returned words for decode
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter int          WORD_SIZE  = 32
) (
    input logic           clk,
    input logic           reset,
    fetch_stage_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    typedef enum logic [1:0] {IDLE, WAIT, SQUASH} state_t;
    state_t               state_q, state_d;
    logic [31:0]          pc_q, pc_d, req_pc_q, req_pc_d;
    logic [WORD_SIZE-1:0] instr_q [FIFO_DEPTH];
    logic [WORD_SIZE-1:0] instr_d [FIFO_DEPTH];
    logic [31:0]          epc_q [FIFO_DEPTH];
    logic [31:0]          epc_d [FIFO_DEPTH];
    logic [PW-1:0]        rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 space, push, pop;
    always_comb begin
        // counting the outstanding request reserves its slot, so a push never overflows
        space           = (count_q + CW'(state_q != IDLE)) < CW'(FIFO_DEPTH);
        bus.readEnable  = state_q == IDLE && !bus.busy && space && !bus.redirect && !reset;
        bus.readAddress = pc_q;
        bus.decValid    = count_q != '0;
        bus.decInstr    = instr_q[rd_q];
        bus.decPC       = epc_q[rd_q];
        push            = state_q == WAIT && bus.ready && !bus.redirect;
        pop             = bus.decValid && bus.decReady;
        instr_d         = instr_q;
        epc_d           = epc_q;
        if (push) begin
            instr_d[wr_q] = bus.instruction;
            epc_d[wr_q]   = req_pc_q;
        end
        rd_d     = bus.redirect ? '0 : rd_q + PW'(pop);
        wr_d     = bus.redirect ? '0 : wr_q + PW'(push);
        count_d  = bus.redirect ? '0 : count_q + CW'(push) - CW'(pop);
        pc_d     = bus.redirect ? bus.redirectPC : bus.readEnable ? pc_q + 32'd4 : pc_q;
        req_pc_d = bus.readEnable ? pc_q : req_pc_q;
        state_d  = state_q == IDLE ? (bus.readEnable ? WAIT : IDLE)
                 : bus.ready ? IDLE : bus.redirect ? SQUASH : state_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            instr_q  <= '{default: '0};
            epc_q    <= '{default: '0};
            rd_q     <= '0;
            wr_q     <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            instr_q  <= instr_d;
            epc_q    <= epc_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and random stimulus against a queue-based model of the fetch stage
module tb_fetch_stage;
    localparam int D = 2;
    typedef struct packed {logic [31:0] i; logic [31:0] p;} ent_t;
    logic clk = 0, reset = 1;
    always #5 clk = ~clk;
    fetch_stage_if #(.WORD_SIZE(32)) bus();
    fetch_stage #(.RESET_PC(32'h0), .FIFO_DEPTH(D), .WORD_SIZE(32)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    int checks = 0, errors = 0;
    ent_t mq[$];
    logic [31:0] m_pc, m_req, last_word, w;
    bit m_pend, m_drop, m_zero, chk_en, acc;
    int cnt = 0, lat_lo = 1, lat_hi = 1;
    function automatic bit exp_re();
        return !reset && !m_pend && !bus.busy && !bus.redirect && (mq.size() + int'(m_pend) < D);
    endfunction
    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", n, a, e, $time);
        end
    endtask
    always @(negedge clk) if (chk_en) begin
        chk("readEnable", 32'(bus.readEnable), 32'(exp_re()));
        chk("readAddress", bus.readAddress, m_pc);
        chk("decValid", 32'(bus.decValid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("decInstr", bus.decInstr, mq[0].i);
            chk("decPC", bus.decPC, mq[0].p);
        end else if (m_zero) begin
            chk("decInstr_zero", bus.decInstr, 32'h0);
            chk("decPC_zero", bus.decPC, 32'h0);
        end
    end
    always @(posedge clk) begin
        bit re, pop;
        re  = exp_re();
        pop = mq.size() != 0 && bus.decReady;
        if (reset) begin
            m_pc = 32'h0; m_pend = 0; m_drop = 0; m_zero = 1;
            mq.delete();
        end else if (bus.redirect) begin
            mq.delete();
            m_pc = bus.redirectPC;
            if (m_pend && bus.ready) m_pend = 0;
            else if (m_pend) m_drop = 1;
        end else begin
            if (pop) void'(mq.pop_front());
            if (m_pend && bus.ready) begin
                if (!m_drop) begin
                    mq.push_back({bus.instruction, m_req});
                    m_zero = 0;
                end
                m_pend = 0;
            end
            if (re) begin
                m_req = m_pc; m_pc = m_pc + 32'd4; m_pend = 1; m_drop = 0;
            end
        end
    end
    task automatic step(bit rst, bit rd, logic [31:0] rpc, bit bz, bit dr, bit spur = 0);
        @(posedge clk);
        #1;
        reset = rst; bus.redirect = rd; bus.redirectPC = rpc; bus.decReady = dr; bus.ready = 0;
        if (acc) cnt = $urandom_range(lat_hi, lat_lo);
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                bus.ready = 1; bus.instruction = $urandom; last_word = bus.instruction;
            end
        end else if (spur && !acc) begin
            bus.ready = 1; bus.instruction = $urandom;
        end
        bus.busy = bz || cnt > 0;
        @(negedge clk);
        acc = bus.readEnable;
    endtask
    task automatic rst_seq();
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        cnt = 0; acc = 0;
    endtask
    initial begin
        bus.redirect = 0; bus.redirectPC = 0; bus.instruction = 0;
        bus.ready = 0; bus.busy = 0; bus.decReady = 0;
        step(1, 0, 0, 0, 0);
        chk_en = 1;
        rst_seq();
        chk("t1_rst_re", 32'(bus.readEnable), 0);
        chk("t1_rst_valid", 32'(bus.decValid), 0);
        chk("t1_rst_instr", bus.decInstr, 0);
        chk("t1_rst_pc", bus.decPC, 0);
        step(0, 0, 0, 0, 1);
        chk("t1_c0_re", 32'(bus.readEnable), 1);
        chk("t1_c0_addr", bus.readAddress, 32'h0);
        step(0, 0, 0, 0, 1); w = last_word;
        step(0, 0, 0, 0, 1);
        chk("t1_c2_valid", 32'(bus.decValid), 1);
        chk("t1_c2_pc", bus.decPC, 32'h0);
        chk("t1_c2_instr", bus.decInstr, w);
        chk("t1_c2_addr", bus.readAddress, 32'h4);
        step(0, 0, 0, 0, 1); w = last_word;
        step(0, 0, 0, 0, 1);
        chk("t1_c4_pc", bus.decPC, 32'h4);
        chk("t1_c4_instr", bus.decInstr, w);
        chk("t1_c4_addr", bus.readAddress, 32'h8);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("t1_c6_pc", bus.decPC, 32'h8);
        rst_seq();
        repeat (10) step(0, 0, 0, 0, 0);
        chk("t2_full_valid", 32'(bus.decValid), 1);
        chk("t2_full_pc", bus.decPC, 32'h0);
        chk("t2_full_re", 32'(bus.readEnable), 0);
        step(0, 0, 0, 0, 1);
        chk("t2_pop0_pc", bus.decPC, 32'h0);
        step(0, 0, 0, 0, 1);
        chk("t2_pop1_pc", bus.decPC, 32'h4);
        chk("t2_resume_re", 32'(bus.readEnable), 1);
        chk("t2_resume_addr", bus.readAddress, 32'h8);
        lat_lo = 6; lat_hi = 6;
        rst_seq();
        step(0, 1, 32'h10, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("t3_addr", bus.readAddress, 32'h10);
        step(0, 0, 0, 0, 1);
        step(0, 1, 32'h100, 0, 1);
        chk("t3_redir_re", 32'(bus.readEnable), 0);
        for (int i = 3; i <= 6; i++) begin
            step(0, 0, 0, 0, 1);
            chk("t3_sq_valid", 32'(bus.decValid), 0);
            chk("t3_sq_re", 32'(bus.readEnable), 0);
        end
        step(0, 0, 0, 0, 1);
        chk("t3_new_re", 32'(bus.readEnable), 1);
        chk("t3_new_addr", bus.readAddress, 32'h100);
        lat_lo = 1; lat_hi = 1;
        rst_seq();
        repeat (3) step(0, 0, 0, 0, 0);
        step(0, 1, 32'h200, 0, 0);
        chk("t4_one_valid", 32'(bus.decValid), 1);
        step(0, 0, 0, 0, 0);
        chk("t4_flush_valid", 32'(bus.decValid), 0);
        chk("t4_re", 32'(bus.readEnable), 1);
        chk("t4_addr", bus.readAddress, 32'h200);
        rst_seq();
        repeat (5) begin
            step(0, 0, 0, 1, 1);
            chk("t5_busy_re", 32'(bus.readEnable), 0);
            chk("t5_busy_addr", bus.readAddress, 32'h0);
        end
        step(0, 0, 0, 0, 1);
        chk("t5_go_re", 32'(bus.readEnable), 1);
        lat_lo = 3; lat_hi = 3;
        rst_seq();
        step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        chk("t6_rst_re", 32'(bus.readEnable), 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("t6_stale_valid", 32'(bus.decValid), 0);
        chk("t6_re", 32'(bus.readEnable), 1);
        chk("t6_addr", bus.readAddress, 32'h0);
        step(0, 0, 0, 0, 1);
        chk("t6_after_valid", 32'(bus.decValid), 0);
        lat_lo = 1; lat_hi = 6;
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 99) == 0, $urandom_range(0, 9) == 0, $urandom & 32'hFFFF_FFFC,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage: owns the program counter and issues one-at-a-time read requests to the instruction memory subsystem (cache plus backing imem) over its `readEnable`/`readAddress`/`instruction`/`ready`/`busy` interface. Returned words are buffered in a small FIFO and handed to decode over a valid/ready handshake. A redirect from execute squashes any in-flight response, flushes the buffer and restarts fetch at the new PC.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `FIFO_DEPTH`, 2, decode buffer entries (power of two, ≥2).
- `WORD_SIZE`, 32, instruction width; matches memory `WORD_SIZE`.

- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `redirect`  in  1  execute requests PC change this cycle.
- `redirectPC`  in  32  new fetch PC when `redirect`=1.
- `readEnable`  out  1  fetch request to memory.
- `readAddress`  out  32  byte address of request (= current PC).
- `instruction`  in  WORD_SIZE  returned word, valid when `ready`=1.
- `ready`  in  1  one-cycle response strobe from memory.
- `busy`  in  1  memory cannot accept a request this cycle.
- `decValid`  out  1  FIFO head valid.
- `decInstr`  out  WORD_SIZE  FIFO head instruction.
- `decPC`  out  32  PC of FIFO head instruction.
- `decReady`  in  1  decode consumes head this cycle.

## Operation
- State machine: IDLE (no request outstanding), WAIT (one outstanding, result kept), SQUASH (one outstanding, result discarded).
- Space rule: issue only if `count + outstanding < FIFO_DEPTH`; guarantees a push never overflows.
- `readEnable` = state==IDLE && !busy && space && !redirect && !reset (combinational). `readAddress` = `pc` always.
- Acceptance: `readEnable`=1 in a cycle ⇒ request accepted; `reqPC` <= `pc`, `pc` <= `pc`+4 (wraps mod 2^32), IDLE→WAIT.
- WAIT + `ready` (no redirect): push {`instruction`, `reqPC`}; →IDLE.
- SQUASH + `ready`: drop word, no push; →IDLE.
- `redirect` (any state, highest priority): FIFO cleared, `pc` <= `redirectPC`; WAIT→SQUASH if `ready`=0, →IDLE if `ready`=1 (word dropped); SQUASH stays SQUASH unless `ready`=1 (→IDLE); IDLE stays IDLE, no issue that cycle.
- Pop: `decValid` && `decReady` removes head; push and pop same cycle allowed at any occupancy, count unchanged.
- `ready` in IDLE (protocol violation) ignored.
- `busy` only blocks issue; it has no effect on an outstanding request.

## Timing
- Reset: `pc`=RESET_PC, state IDLE, FIFO empty, storage zeroed; `readEnable`=0, `decValid`=0, `decInstr`=0, `decPC`=0 during and after reset until first push. Reset mid-request returns to IDLE; a later `ready` for that request is ignored (state IDLE).
- Memory contract: at most one outstanding request; `ready` no earlier than cycle after acceptance.
- Acceptance cycle N, `ready` at M≥N+1 ⇒ `decValid`=1 at M+1 with that word; next `readEnable` earliest M+1 (PC+4).
- Best-case throughput one instruction per 2 cycles (1-cycle hit latency).
- Redirect at cycle R ⇒ `decValid`=0 at R+1; first `readEnable` at `redirectPC` earliest R+1 (IDLE) or the cycle after the squashed `ready`.
- `decInstr`/`decPC` don't-care when `decValid`=0.

## Test plan
- Reset release, memory `ready` 1 cycle after each accept, `decReady`=1 -> requests to 0x0,0x4,0x8 at cycles 0,2,4; `decPC` 0x0,0x4,0x8 each with matching word, `decValid` at cycles 2,4,6.
- `decReady`=0 held -> two words buffered, `readEnable` stays 0; raise `decReady` -> heads pop in order, fetch resumes at 0x8.
- Request 0x10 accepted, miss latency 6 cycles, `redirect`=1 with 0x100 at cycle 2 -> word for 0x10 never reaches `decValid`; next `readEnable` with 0x100 the cycle after `ready`.
- `redirect` to 0x200 in same cycle as `ready` with FIFO holding one entry -> FIFO empty next cycle, returned word dropped, `readEnable` at 0x200 next cycle.
- `busy`=1 for 5 cycles in IDLE -> `readEnable` 0 throughout, `pc` unchanged; issues on first cycle `busy`=0.
- Assert `reset` while in WAIT, then `ready` -> no push, `decValid`=0, next request at RESET_PC.
